riscv_rf_writeback_arbiter: RTL and testbench

- Write-side master for the latch-based register file.
- Collects result writes from NUM_SRC producers (ALU, multiplier, LSU, FPU) over valid/ready.
- Grants up to two per cycle round-robin and drives the register file's two write ports from flops.
- Keeps a per-register pending-write scoreboard (busy bits) for decode hazard checks.

---
 rtl/riscv_rf_writeback_arbiter_pkg.sv | 33 +++
 rtl/riscv_rf_writeback_arbiter_rr_pick.sv | 66 ++++++
 rtl/riscv_rf_writeback_arbiter.sv | 128 ++++++++++++
 tb/tb_riscv_rf_writeback_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_rf_writeback_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_wb_pkg
// Purpose  : Shared constants, types and helpers for the register-file
//            write-back arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_wb_pkg;

    // Canonical producer port assignment
    localparam int unsigned SRC_ALU  = 0;
    localparam int unsigned SRC_MULT = 1;
    localparam int unsigned SRC_LSU  = 2;
    localparam int unsigned SRC_FPU  = 3;

    // Default write-back geometry
    localparam int unsigned WB_ADDR_W = 5;
    localparam int unsigned WB_DATA_W = 32;

    // One producer write request
    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    // Rotating-pointer successor: idx + 1 wrapped to the source count
    function automatic int unsigned rr_next(input int unsigned idx,
                                            input int unsigned num_src);
        return (idx + 1 >= num_src) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_rf_writeback_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : riscv_wb_rr_pick
// Purpose  : Combinational two-grant rotating picker. Scans producers from the
//            round-robin pointer, gives port A to the first non-x0 request and
//            port B to the next one whose address differs from port A. x0
//            requests are acknowledged without using a port.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_wb_rr_pick
    import riscv_wb_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned PTR_W      = 2
) (
    input  logic [NUM_SRC-1:0]                 valid,
    input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0] addr,
    input  logic [PTR_W-1:0]                   rr,
    output logic [NUM_SRC-1:0]                 ready,
    output logic                               gnt_a,
    output logic                               gnt_b,
    output logic [PTR_W-1:0]                   sel_a,
    output logic [PTR_W-1:0]                   sel_b,
    output logic [PTR_W-1:0]                   rr_nxt
);

    int               w_pos;
    logic [PTR_W-1:0] w_idx;

    // Rotating scan; pointer advances past the last port grant only
    always_comb begin
        ready  = '0;
        gnt_a  = 1'b0;
        gnt_b  = 1'b0;
        sel_a  = '0;
        sel_b  = '0;
        rr_nxt = rr;
        w_pos  = 0;
        w_idx  = '0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            w_pos = int'(rr) + k;
            if (w_pos >= int'(NUM_SRC)) begin
                w_pos = w_pos - int'(NUM_SRC);
            end
            w_idx = PTR_W'(w_pos);
            if (valid[w_idx]) begin
                if (addr[w_idx] == '0) begin
                    ready[w_idx] = 1'b1;
                end else if (!gnt_a) begin
                    gnt_a        = 1'b1;
                    sel_a        = w_idx;
                    ready[w_idx] = 1'b1;
                    rr_nxt       = PTR_W'(rr_next(unsigned'(w_pos), NUM_SRC));
                end else if (!gnt_b && (addr[w_idx] != addr[sel_a])) begin
                    gnt_b        = 1'b1;
                    sel_b        = w_idx;
                    ready[w_idx] = 1'b1;
                    rr_nxt       = PTR_W'(rr_next(unsigned'(w_pos), NUM_SRC));
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/riscv_rf_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : riscv_rf_writeback_arbiter
// Purpose  : Write-side master for the latch-based register file. Accepts up
//            to two producer writes per cycle, drives both RF write ports from
//            flops and tracks pending writes per register for decode.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_rf_writeback_arbiter
    import riscv_wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_SRC    = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_SRC-1:0]                 src_valid_i,
    input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0] src_addr_i,
    input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] src_data_i,
    output logic [NUM_SRC-1:0]                 src_ready_o,
    input  logic                               reserve_valid_i,
    input  logic [ADDR_WIDTH-1:0]              reserve_addr_i,
    output logic [(2**ADDR_WIDTH)-1:0]         busy_o,
    output logic                               we_a_o,
    output logic [ADDR_WIDTH-1:0]              waddr_a_o,
    output logic [DATA_WIDTH-1:0]              wdata_a_o,
    output logic                               we_b_o,
    output logic [ADDR_WIDTH-1:0]              waddr_b_o,
    output logic [DATA_WIDTH-1:0]              wdata_b_o
);

    localparam int unsigned PTR_W   = $clog2(NUM_SRC);
    localparam int unsigned NUM_REG = 2**ADDR_WIDTH;

    logic [PTR_W-1:0]      r_rr;
    logic [PTR_W-1:0]      w_rr_nxt;
    logic                  w_gnt_a;
    logic                  w_gnt_b;
    logic [PTR_W-1:0]      w_sel_a;
    logic [PTR_W-1:0]      w_sel_b;
    logic [NUM_SRC-1:0]    w_ready;

    logic                  r_we_a;
    logic [ADDR_WIDTH-1:0] r_waddr_a;
    logic [DATA_WIDTH-1:0] r_wdata_a;
    logic                  r_we_b;
    logic [ADDR_WIDTH-1:0] r_waddr_b;
    logic [DATA_WIDTH-1:0] r_wdata_b;
    logic [NUM_REG-1:0]    r_busy;
    logic [NUM_REG-1:0]    w_busy_nxt;

    riscv_wb_rr_pick #(
        .NUM_SRC    (NUM_SRC),
        .ADDR_WIDTH (ADDR_WIDTH),
        .PTR_W      (PTR_W)
    ) u_pick (
        .valid  (src_valid_i),
        .addr   (src_addr_i),
        .rr     (r_rr),
        .ready  (w_ready),
        .gnt_a  (w_gnt_a),
        .gnt_b  (w_gnt_b),
        .sel_a  (w_sel_a),
        .sel_b  (w_sel_b),
        .rr_nxt (w_rr_nxt)
    );

    // Pending-write bitmap: granted writes clear, reservations set (set wins)
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_gnt_a) begin
            w_busy_nxt[src_addr_i[w_sel_a]] = 1'b0;
        end
        if (w_gnt_b) begin
            w_busy_nxt[src_addr_i[w_sel_b]] = 1'b0;
        end
        if (reserve_valid_i) begin
            w_busy_nxt[reserve_addr_i] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Round-robin pointer and scoreboard state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr   <= '0;
            r_busy <= '0;
        end else begin
            r_rr   <= w_rr_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    // Registered RF write ports; address/data hold when no grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we_a    <= 1'b0;
            r_waddr_a <= '0;
            r_wdata_a <= '0;
            r_we_b    <= 1'b0;
            r_waddr_b <= '0;
            r_wdata_b <= '0;
        end else begin
            r_we_a <= w_gnt_a;
            r_we_b <= w_gnt_b;
            if (w_gnt_a) begin
                r_waddr_a <= src_addr_i[w_sel_a];
                r_wdata_a <= src_data_i[w_sel_a];
            end
            if (w_gnt_b) begin
                r_waddr_b <= src_addr_i[w_sel_b];
                r_wdata_b <= src_data_i[w_sel_b];
            end
        end
    end

    assign src_ready_o = w_ready;
    assign busy_o      = r_busy;
    assign we_a_o      = r_we_a;
    assign waddr_a_o   = r_waddr_a;
    assign wdata_a_o   = r_wdata_a;
    assign we_b_o      = r_we_b;
    assign waddr_b_o   = r_waddr_b;
    assign wdata_b_o   = r_wdata_b;

endmodule
`default_nettype wire

// File: tb/tb_riscv_rf_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_rf_writeback_arbiter
// Purpose  : Scoreboard bench for the write-back arbiter. Producers are fed
//            from per-source request queues; a reference model predicts
//            ready, write ports and busy bits; a monitor compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_rf_writeback_arbiter;

    localparam int NS = 4;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 1 << AW;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NS-1:0]         src_valid_i;
    logic [NS-1:0][AW-1:0] src_addr_i;
    logic [NS-1:0][DW-1:0] src_data_i;
    logic [NS-1:0]         src_ready_o;
    logic                  reserve_valid_i;
    logic [AW-1:0]         reserve_addr_i;
    logic [NR-1:0]         busy_o;
    logic                  we_a_o;
    logic [AW-1:0]         waddr_a_o;
    logic [DW-1:0]         wdata_a_o;
    logic                  we_b_o;
    logic [AW-1:0]         waddr_b_o;
    logic [DW-1:0]         wdata_b_o;

    riscv_rf_writeback_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_SRC    (NS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .src_valid_i     (src_valid_i),
        .src_addr_i      (src_addr_i),
        .src_data_i      (src_data_i),
        .src_ready_o     (src_ready_o),
        .reserve_valid_i (reserve_valid_i),
        .reserve_addr_i  (reserve_addr_i),
        .busy_o          (busy_o),
        .we_a_o          (we_a_o),
        .waddr_a_o       (waddr_a_o),
        .wdata_a_o       (wdata_a_o),
        .we_b_o          (we_b_o),
        .waddr_b_o       (waddr_b_o),
        .wdata_b_o       (wdata_b_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_t;

    typedef struct {
        logic          we_a;
        logic [AW-1:0] wa;
        logic [DW-1:0] da;
        logic          we_b;
        logic [AW-1:0] wb;
        logic [DW-1:0] db;
        logic [NR-1:0] busy;
    } exp_t;

    req_t          sq [NS][$];
    logic [AW-1:0] res_q[$];
    logic [NS-1:0] rdy_q[$];
    exp_t          out_q[$];
    bit            rand_mode = 1'b0;
    int            checks    = 0;
    int            failures  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NR-1)) : AW'($urandom_range(0, 7));
        r.d = $urandom;
        return r;
    endfunction

    function automatic req_t mk(input int a, input logic [DW-1:0] d);
        req_t r;
        r.a = AW'(a);
        r.d = d;
        return r;
    endfunction

    // Producer side: present queue heads, pop on observed handshake
    initial begin : driver
        logic [NS-1:0] acc;
        src_valid_i     = '0;
        src_addr_i      = '0;
        src_data_i      = '0;
        reserve_valid_i = 1'b0;
        reserve_addr_i  = '0;
        forever begin
            @(negedge clk);
            acc = src_valid_i & src_ready_o & {NS{rst_n}};
            if (!rst_n) begin
                for (int i = 0; i < NS; i++) sq[i].delete();
                res_q.delete();
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (acc[i] && sq[i].size() > 0) void'(sq[i].pop_front());
                if (rand_mode && rst_n && sq[i].size() == 0 && $urandom_range(0, 2) != 0)
                    sq[i].push_back(rand_req());
                if (rst_n && sq[i].size() > 0) begin
                    src_valid_i[i] = 1'b1;
                    src_addr_i[i]  = sq[i][0].a;
                    src_data_i[i]  = sq[i][0].d;
                end else begin
                    src_valid_i[i] = 1'b0;
                end
            end
            if (rst_n && res_q.size() > 0) begin
                reserve_valid_i = 1'b1;
                reserve_addr_i  = res_q.pop_front();
            end else if (rst_n && rand_mode && $urandom_range(0, 2) == 0) begin
                reserve_valid_i = 1'b1;
                reserve_addr_i  = AW'($urandom_range(0, 15));
            end else begin
                reserve_valid_i = 1'b0;
            end
        end
    end

    // Reference model: rotating priority over the request list, two distinct
    // non-zero addresses per cycle, x0 acknowledged for free
    initial begin : model
        int            rr;
        int            i;
        int            granted[$];
        logic [NS-1:0] rdy;
        exp_t          cur;
        rr  = 0;
        cur = '{default: 0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rr  = 0;
                cur = '{default: 0};
                out_q.delete();
                rdy_q.delete();
                out_q.push_back(cur);
            end else begin
                rdy = '0;
                granted.delete();
                for (int k = 0; k < NS; k++) begin
                    i = (rr + k) % NS;
                    if (src_valid_i[i]) begin
                        if (src_addr_i[i] == 0) begin
                            rdy[i] = 1'b1;
                        end else if (granted.size() == 0 ||
                                     (granted.size() == 1 && src_addr_i[i] != src_addr_i[granted[0]])) begin
                            granted.push_back(i);
                            rdy[i] = 1'b1;
                        end
                    end
                end
                cur.we_a = (granted.size() > 0);
                cur.we_b = (granted.size() > 1);
                if (granted.size() > 0) begin
                    cur.wa = src_addr_i[granted[0]];
                    cur.da = src_data_i[granted[0]];
                end
                if (granted.size() > 1) begin
                    cur.wb = src_addr_i[granted[1]];
                    cur.db = src_data_i[granted[1]];
                end
                foreach (granted[g]) cur.busy[src_addr_i[granted[g]]] = 1'b0;
                if (reserve_valid_i && reserve_addr_i != 0) cur.busy[reserve_addr_i] = 1'b1;
                if (granted.size() > 0) rr = (granted[granted.size()-1] + 1) % NS;
                rdy_q.push_back(rdy);
                out_q.push_back(cur);
            end
        end
    end

    // Monitor: compare DUT against the model once per cycle, mid-low-phase
    initial begin : monitor
        exp_t          e;
        logic [NS-1:0] r;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (rdy_q.size() == 0 || out_q.size() < 2) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_underflow actual=%0d required=2", out_q.size());
                end else begin
                    r = rdy_q.pop_front();
                    e = out_q.pop_front();
                    check("src_ready", 64'(src_ready_o), 64'(r));
                    check("we_a",      64'(we_a_o),      64'(e.we_a));
                    check("waddr_a",   64'(waddr_a_o),   64'(e.wa));
                    check("wdata_a",   64'(wdata_a_o),   64'(e.da));
                    check("we_b",      64'(we_b_o),      64'(e.we_b));
                    check("waddr_b",   64'(waddr_b_o),   64'(e.wb));
                    check("wdata_b",   64'(wdata_b_o),   64'(e.db));
                    check("busy",      64'(busy_o),      64'(e.busy));
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            #1;
            if (sq[0].size() == 0 && sq[1].size() == 0 && sq[2].size() == 0 && sq[3].size() == 0 &&
                res_q.size() == 0 && src_valid_i == '0 && !reserve_valid_i) begin
                done = 1'b1;
            end else if (++n > 200) begin
                checks++;
                failures++;
                $display("FAIL %s_idle_timeout actual=%0d cycles required=idle", name, n);
                done = 1'b1;
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit seen;
        rst_n = 1'b0;
        #23;
        check("reset_we_a",    64'(we_a_o),    64'(0));
        check("reset_we_b",    64'(we_b_o),    64'(0));
        check("reset_waddr_a", 64'(waddr_a_o), 64'(0));
        check("reset_wdata_b", 64'(wdata_b_o), 64'(0));
        check("reset_busy",    64'(busy_o),    64'(0));
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Four sources, distinct addresses
        for (int s = 0; s < NS; s++) sq[s].push_back(mk(s + 1, $urandom));
        wait_idle("four_src");
        // Single write
        sq[0].push_back(mk(5, 32'hDEADBEEF));
        wait_idle("single");
        // Same-address conflict
        sq[1].push_back(mk(7, 32'h1111_0001));
        sq[2].push_back(mk(7, 32'h2222_0002));
        wait_idle("conflict");
        // x0 request next to a real one
        sq[0].push_back(mk(0, 32'h0BAD_0BAD));
        sq[1].push_back(mk(9, 32'h0000_0009));
        wait_idle("x0_drop");
        // Scoreboard set, clear, and simultaneous set/clear
        res_q.push_back(AW'(12));
        wait_idle("reserve");
        sq[0].push_back(mk(12, 32'hC0DE_000C));
        wait_idle("clear");
        res_q.push_back(AW'(12));
        sq[0].push_back(mk(12, 32'hC0DE_100C));
        wait_idle("set_clear");
        res_q.push_back(AW'(0));
        wait_idle("reserve_x0");

        // Asynchronous reset while a write is on the port
        sq[0].push_back(mk(3, 32'h3333_3333));
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (we_a_o) seen = 1'b1;
        end
        check("pre_reset_we_a", 64'(we_a_o), 64'(1));
        check("pre_reset_busy", 64'(busy_o), 64'(32'h0000_1000));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_we_a",    64'(we_a_o),    64'(0));
        check("async_we_b",    64'(we_b_o),    64'(0));
        check("async_busy",    64'(busy_o),    64'(0));
        check("async_waddr_a", 64'(waddr_a_o), 64'(0));
        check("async_wdata_a", 64'(wdata_a_o), 64'(0));
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Randomised traffic with frequent address collisions
        rand_mode = 1'b1;
        repeat (400) @(posedge clk);
        #2;
        rand_mode = 1'b0;
        wait_idle("random");
        repeat (3) @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
